// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory byte-stream loader.
//   loader_state_t : FSM state encoding (also driven out on the debug port)
//   ADDR_HI_IDX / ADDR_LO_IDX : position of the two address bytes in a session header
//   word_bytes()   : bytes needed to carry one instruction-buffer word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    DATA    = 3'd3,
    WRITE   = 3'd4
  } loader_state_t;

  localparam int ADDR_HI_IDX = 0;
  localparam int ADDR_LO_IDX = 1;

  // ceil(i_width * i_buffer_size / 8)
  function automatic int word_bytes(input int iw, input int bs);
    return (iw * bs + 7) / 8;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: assembles a framed host byte stream into instruction-memory
// words and writes them with an auto-incrementing address.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   host_data/valid   stream byte and its valid qualifier
//   host_sof/eof      first / last byte of a session (only with host_valid)
//   host_ready        byte accepted on a clock where host_valid & host_ready
//   imem_write_adr    write address
//   imem_write        one-cycle write strobe
//   imem_in           write data (i_buffer_size*i_width bits)
//   busy              session in progress
//   words_written     words written this session (saturating)
//   frame_err         sticky protocol error, cleared by SOF accepted in IDLE
//   dbg_state         current FSM state
//
// Handshake: a byte transfers on every rising edge where host_valid and
// host_ready are both high. host_ready is registered and is low only during
// the WRITE cycle; the host may hold host_valid high continuously.
//
// Session: ADDR_HI, ADDR_LO, then whole words of B bytes, most significant
// byte first, with host_eof on the last byte of the last word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int d_width       = 8,
  parameter int i_adr_width   = 10,
  parameter int i_width       = 20,
  parameter int i_buffer_size = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [d_width-1:0]                host_data,
  input  logic                              host_valid,
  input  logic                              host_sof,
  input  logic                              host_eof,
  output logic                              host_ready,
  output logic [i_adr_width-1:0]            imem_write_adr,
  output logic                              imem_write,
  output logic [i_buffer_size*i_width-1:0]  imem_in,
  output logic                              busy,
  output logic [i_adr_width:0]              words_written,
  output logic                              frame_err,
  output loader_state_t                     dbg_state
);

  localparam int W      = i_buffer_size * i_width;
  localparam int B      = word_bytes(i_width, i_buffer_size);
  localparam int SW     = B * d_width;      // full assembled byte span
  localparam int HOLD_W = SW - d_width;     // bytes held before the last one
  localparam int HI_W   = i_adr_width - 8;  // address bits carried by ADDR_HI
  localparam int CNT_W  = (B > 1) ? $clog2(B) : 1;
  localparam int AW1    = i_adr_width + 1;

  loader_state_t          state_q, state_d;
  logic [HI_W-1:0]        hi_q, hi_d;
  logic [i_adr_width-1:0] addr_q, addr_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   eof_q, eof_d;     // word in WRITE closes the session
  logic                   wrap_q, wrap_d;   // address wrapped; next write is an error

  logic                   ready_d, write_d, busy_d, ferr_d;
  logic [i_adr_width-1:0] wadr_d;
  logic [W-1:0]           win_d;
  logic [AW1-1:0]         words_d;
  logic [SW-1:0]          word;
  logic                   accept;

  assign dbg_state = state_q;
  assign accept    = host_valid & host_ready;
  assign word      = {hold_q, host_data};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    eof_d   = eof_q;
    wrap_d  = wrap_q;
    busy_d  = busy;
    ferr_d  = frame_err;
    words_d = words_written;
    write_d = 1'b0;
    wadr_d  = imem_write_adr;
    win_d   = imem_in;

    if (accept && host_sof) begin
      // New session; outside IDLE this is a resync, which is itself an error
      // and does not clear a pending one.
      hi_d    = host_data[HI_W-1:0];
      words_d = '0;
      wrap_d  = 1'b0;
      busy_d  = 1'b1;
      ferr_d  = (state_q != IDLE) ? 1'b1 : 1'b0;
      state_d = ADDR_LO;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) ferr_d = 1'b1;  // stray byte outside a session
        end
        ADDR_HI: begin
          if (accept) begin
            hi_d    = host_data[HI_W-1:0];
            state_d = ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (accept) begin
            if (host_eof) begin
              ferr_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              addr_d  = {hi_q, host_data[7:0]};
              cnt_d   = '0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            hold_d = word[HOLD_W-1:0];
            if (cnt_q == CNT_W'(B - 1)) begin
              write_d = 1'b1;
              wadr_d  = addr_q;
              win_d   = word[W-1:0];
              eof_d   = host_eof;
              if (wrap_q) begin
                ferr_d = 1'b1;
                wrap_d = 1'b0;
              end
              state_d = WRITE;
            end else if (host_eof) begin
              ferr_d  = 1'b1;  // short word: drop it and end the session
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          addr_d = addr_q + i_adr_width'(1);
          if (words_written != '1) words_d = words_written + AW1'(1);
          if (addr_q == '1 && !eof_q) wrap_d = 1'b1;
          if (eof_q) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d != WRITE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      hi_q           <= '0;
      addr_q         <= '0;
      hold_q         <= '0;
      cnt_q          <= '0;
      eof_q          <= 1'b0;
      wrap_q         <= 1'b0;
      host_ready     <= 1'b0;
      imem_write     <= 1'b0;
      imem_write_adr <= '0;
      imem_in        <= '0;
      busy           <= 1'b0;
      words_written  <= '0;
      frame_err      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hi_q           <= hi_d;
      addr_q         <= addr_d;
      hold_q         <= hold_d;
      cnt_q          <= cnt_d;
      eof_q          <= eof_d;
      wrap_q         <= wrap_d;
      host_ready     <= ready_d;
      imem_write     <= write_d;
      imem_write_adr <= wadr_d;
      imem_in        <= win_d;
      busy           <= busy_d;
      words_written  <= words_d;
      frame_err      <= ferr_d;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that sits directly upstream of the `digital` top's instruction-memory write port.
- Accepts a framed byte stream from the host / test interface over a valid/ready handshake.
- Assembles the bytes into `i_buffer_size*i_width`-bit instruction-buffer words.
- Issues single-cycle write strobes with an auto-incrementing address.
- Raises `busy` for the whole session so the top level can hold the PAT core in reset while code is loaded.

## Interface
- `d_width`, 8: host byte width.
- `i_adr_width`, 10: instruction-memory address width; legal range 9..16.
- `i_width`, 20: instruction width.
- `i_buffer_size`, 2: instructions per memory word.
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `host_data`  in  `d_width`  stream byte.
- `host_valid`  in  1  byte present.
- `host_sof`  in  1  qualifies the first byte of a session; meaningful only with `host_valid`.
- `host_eof`  in  1  qualifies the last byte of a session; meaningful only with `host_valid`.
- `host_ready`  out  1  byte accepted when `host_valid & host_ready`.
- `imem_write_adr`  out  `i_adr_width`  write address.
- `imem_write`  out  1  one-cycle write strobe.
- `imem_in`  out  `i_buffer_size*i_width`  write data.
- `busy`  out  1  session active.
- `words_written`  out  `i_adr_width+1`  words written this session.
- `frame_err`  out  1  sticky protocol error; cleared by the next accepted SOF byte.

## Operation
- Definitions:
  - W = `i_buffer_size*i_width` (40 by default).
  - B = ceil(W/8) bytes per word (5 by default).
- Session format: ADDR_HI byte, ADDR_LO byte, then N×B data bytes.
  - Data bytes are big-endian: the first byte is most significant.
  - Bits of the first byte above W are discarded.
  - `host_eof` must accompany the final byte of a word.
- Start address = {ADDR_HI[`i_adr_width`-9:0], ADDR_LO}.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, WRITE.
- IDLE:
  - An accepted byte with SOF loads it as ADDR_HI, sets `busy`, clears `frame_err` and `words_written`, then moves to ADDR_LO.
  - An accepted byte without SOF is dropped and sets `frame_err`.
- ADDR_LO: accepted byte → DATA, byte counter = 0.
- DATA:
  - Each accepted byte shifts into the word register and increments the byte counter.
  - On byte B-1 → WRITE.
  - If EOF arrives before byte B-1: the partial word is discarded, `frame_err` is set, `busy` drops → IDLE.
- WRITE (one cycle):
  - `imem_write`=1; `imem_write_adr` = current address; `imem_in` = assembled word.
  - Then address +1 and `words_written` +1.
  - If that last word carried EOF → IDLE with `busy`=0; otherwise → DATA.
- SOF in any non-IDLE state (resync):
  - Sets `frame_err`.
  - The byte is taken as ADDR_HI and the session restarts; any partial word is discarded.
  - `frame_err` stays set, because the SOF clear applies only in IDLE.
- Address wrap: the address increments modulo 2^`i_adr_width`. Writing at address 2^`i_adr_width`-1 followed by another word sets `frame_err`; the next write lands at 0.
- `words_written` saturates at its maximum value.

## Timing
- Reset values: `host_ready`=0, `imem_write`=0, `imem_write_adr`=0, `imem_in`=0, `busy`=0, `words_written`=0, `frame_err`=0, state IDLE.
- `host_ready` is registered:
  - 1 from the first clock after reset release.
  - 0 only during the WRITE cycle.
- All outputs are registered.
- `imem_write` asserts on the clock after the B-th data byte is accepted.
- Sustained throughput: one word per B+1 cycles.
- `busy` rises on the clock that accepts SOF and falls on the clock after the final WRITE, or after an error drop.
- Reset asserted mid-session: immediate return to the reset values; the partially written memory is left as is.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum;
  - the function computing B from `i_width` and `i_buffer_size`;
  - the ADDR_HI/ADDR_LO byte-index constants.
- Single module with no sub-module. The byte shift register and FSM are inline.

## Test plan
- Address and data assembly: SOF 0x01, 0x23, then bytes 0x0A 0xBC 0xDE 0xF0 0x12 with EOF on the last byte.
  - Expect one `imem_write` at address 0x123 with data 0x0ABCDEF012.
  - Expect `words_written`=1, `busy` low afterwards, `frame_err`=0.
- Continuous stream: start address 0x000, 3 words, `host_valid` held high throughout.
  - Expect writes at 0, 1, 2, each 6 cycles apart.
  - Expect `host_ready` low exactly in each write cycle.
- Wrap: start address 0x3FF, 2 words.
  - Expect writes at 0x3FF then 0x000, with `frame_err`=1.
- Short frame: EOF on the 3rd data byte.
  - Expect no write, `frame_err`=1, `busy`=0, and the next SOF session clears `frame_err`.
- Resync: SOF arrives mid-word.
  - Expect the partial word discarded and the new address used for the next write.
- Async reset mid-word:
  - Expect every output at its reset value immediately.
  - Expect `host_ready`=1 one clock after release.
